// File: rtl/shared_delay_arbiter.sv
// shared_delay_arbiter
//
// One cycle-delay counter shared by NUM_REQ requesters. Pending requests are
// granted round-robin, one job at a time. The granted requester's delay is
// counted on the shared counter, and completion is reported with a one-cycle
// one-hot pulse on `done`.
//
// Optional feature macro: SHARED_DELAY_ABORT_EN
//   When defined, a granted requester that drops its req during RUN aborts
//   the job. The block returns to IDLE with no done, and rr_ptr advances as
//   on a normal completion. When undefined, every grant ends with done.
//
// Handshake: req[i] is a level. It stays high until the cycle in which
// done[i] is high, and must be low at the edge that ends that cycle;
// otherwise it counts as a fresh request. req_cycles slice i is sampled only
// at the grant edge.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   req         in   [NUM_REQ]          level request per requester
//   req_cycles  in   [NUM_REQ*COUNT_W]  delay per requester, slice i = [i*COUNT_W +: COUNT_W]
//   busy        out  high in RUN and DONE
//   grant_id    out  [ID_W]             current/last granted requester
//   done        out  [NUM_REQ]          one-hot completion pulse
//   remaining   out  [COUNT_W]          target-1-count during RUN, else 0
//   fsm_state   out  [2]                current FSM state (0 IDLE, 1 RUN, 2 DONE)
module shared_delay_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COUNT_W = 16,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COUNT_W-1:0] req_cycles,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id,
    output logic [NUM_REQ-1:0]         done,
    output logic [COUNT_W-1:0]         remaining,
    output logic [1:0]                 fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] target;

    // Round-robin search result. It is only consumed at an IDLE edge.
    logic               any_req;
    logic [ID_W-1:0]    winner;
    logic [COUNT_W-1:0] winner_cycles;
    logic               found;
    int                 search_idx;

    // rr_ptr value used after a job ends, whether it completed or aborted.
    logic [ID_W-1:0]    next_ptr;

    always_comb begin
        any_req       = |req;
        winner        = rr_ptr;
        winner_cycles = '0;
        found         = 1'b0;
        search_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            search_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[search_idx]) begin
                found         = 1'b1;
                winner        = ID_W'(search_idx);
                winner_cycles = req_cycles[search_idx*COUNT_W +: COUNT_W];
            end
        end
    end

    always_comb begin
        if (grant_id == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            count    <= '0;
            target   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        // A zero delay is treated as one cycle, so done always
                        // follows the grant edge by at least one edge.
                        target   <= (winner_cycles == '0) ? COUNT_W'(1) : winner_cycles;
                        count    <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    count <= count + COUNT_W'(1);
`ifdef SHARED_DELAY_ABORT_EN
                    // An abort takes priority over completion on the same edge.
                    if (!req[grant_id]) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                    end else if (count == target - COUNT_W'(1)) begin
                        state <= ST_DONE;
                    end
`else
                    if (count == target - COUNT_W'(1)) begin
                        state <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_ptr;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only. Nothing depends
    // combinationally on req.
    always_comb begin
        busy      = (state == ST_RUN) || (state == ST_DONE);
        fsm_state = state;
        done      = '0;
        if (state == ST_DONE) begin
            done[grant_id] = 1'b1;
        end
        if (state == ST_RUN) begin
            remaining = target - COUNT_W'(1) - count;
        end else begin
            remaining = '0;
        end
    end

endmodule

// File: tb/tb_shared_delay_arbiter.sv
// Testbench for shared_delay_arbiter with NUM_REQ=4 and COUNT_W=16.
// Each expected completion is queued as {grant_id, done mask, latency} when a
// job is driven. A negedge monitor pops the entry when done fires and checks
// the mask, the grant_id, the latency from the grant, the busy length and the
// remaining count.
module tb_shared_delay_arbiter;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int W  = 22;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*CW-1:0] req_cycles;
    logic            busy;
    logic [1:0]      grant_id;
    logic [N-1:0]    done;
    logic [CW-1:0]   remaining;
    logic [1:0]      fsm_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    int         cyc            = 0;
    int         grant_cyc      = 0;
    int         last_lat       = 0;
    bit         last_lat_valid = 1'b0;
    logic       prev_busy      = 1'b0;
    logic [N-1:0] prev_done    = '0;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] cycles;
        int          exp_id;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    shared_delay_arbiter #(.NUM_REQ(N), .COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_cycles (req_cycles),
        .busy       (busy),
        .grant_id   (grant_id),
        .done       (done),
        .remaining  (remaining),
        .fsm_state  (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Counts negedges until done is seen, up to the given limit.
    task automatic wait_done(input int limit, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            waited++;
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_done");
    endtask

    task automatic wait_busy(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_busy");
    endtask

    task automatic push_exp(input int id, input int lat);
        logic [1:0]  id_b;
        logic [3:0]  m;
        logic [15:0] l;
        id_b = id[1:0];
        m    = 4'b0001 << id;
        l    = lat[15:0];
        exp_q.push_back({id_b, m, l});
    endtask

    // Drives one job. Non-winning slots get other delays, so a wrong slice
    // select shows up as a wrong latency.
    task automatic run_job(input logic [3:0] mask, input logic [15:0] cycles, input int exp_id);
        bit ok;
        int waited;
        for (int k = 0; k < N; k++) begin
            req_cycles[k*CW +: CW] = (k == exp_id) ? cycles : cycles + 16'(k + 1);
        end
        push_exp(exp_id, (cycles == 16'd0) ? 1 : int'(cycles));
        req = mask;
        wait_done(1000, ok, waited);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (busy && !prev_busy) grant_cyc = cyc;
                if (!busy && prev_busy && last_lat_valid) begin
                    check("busy_len", cyc - grant_cyc, last_lat + 1);
                    last_lat_valid = 1'b0;
                end
                if (prev_done != '0) check("done_width", done, 0);
                if (done != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_mask", done, e[19:16]);
                        check("grant_id", grant_id, e[21:20]);
                        check("latency", cyc - grant_cyc, e[15:0]);
                        last_lat       = int'(e[15:0]);
                        last_lat_valid = 1'b1;
                    end
                end else if (busy && exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("remaining", remaining, int'(e[15:0]) - 1 - (cyc - grant_cyc));
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    initial begin : driver
        bit ok;
        int waited;

        reset      = 1'b1;
        req        = '0;
        req_cycles = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_remaining", remaining, 0);
        check("rst_state", fsm_state, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Expected winners follow rr_ptr, which starts at 0 after reset.
        vecs[0] = '{4'b0001, 16'd5,   0};  // rr -> 1
        vecs[1] = '{4'b0100, 16'd0,   2};  // zero delay, rr -> 3
        vecs[2] = '{4'b1011, 16'd3,   3};  // search from 3, rr -> 0
        vecs[3] = '{4'b0110, 16'd1,   1};  // rr -> 2
        vecs[4] = '{4'b0011, 16'd7,   0};  // wraps past 2,3, rr -> 1
        vecs[5] = '{4'b1100, 16'd2,   2};  // rr -> 3
        vecs[6] = '{4'b1111, 16'd12,  3};  // rr -> 0
        vecs[7] = '{4'b0001, 16'd300, 0};  // long delay, rr -> 1
        for (int v = 0; v < 8; v++) begin
            run_job(vecs[v].mask, vecs[v].cycles, vecs[v].exp_id);
        end

        // Round-robin: all requesting, each drops its line after its done.
        do_reset();
        for (int k = 0; k < N; k++) req_cycles[k*CW +: CW] = 16'd3;
        for (int k = 0; k < N; k++) push_exp(k, 3);
        req = 4'b1111;
        for (int j = 0; j < N; j++) begin
            wait_done(200, ok, waited);
            if (!ok) break;
            if (j > 0) check("rr_spacing", waited, 5);
            req = req & ~done;
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Mid-operation reset: a job on 0 moves rr_ptr to 1, then requester 1 is reset at count 7.
        run_job(4'b0001, 16'd4, 0);
        req_cycles[1*CW +: CW] = 16'd20;
        req = 4'b0010;
        wait_busy(50, ok);
        repeat (7) @(negedge clk);
        check("mid_remaining", remaining, 12);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_remaining", remaining, 0);
        check("mid_rst_state", fsm_state, 0);
        check("mid_rst_grant_id", grant_id, 0);
        repeat (30) @(negedge clk);
        run_job(4'b0011, 16'd6, 0);

        // Dropping req[1] at count 4 of a 10-cycle job.
        req_cycles[1*CW +: CW] = 16'd10;
`ifdef SHARED_DELAY_ABORT_EN
        req = 4'b0010;
        wait_busy(50, ok);
        repeat (4) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_state", fsm_state, 0);
        repeat (15) @(negedge clk);
`else
        push_exp(1, 10);
        req = 4'b0010;
        wait_busy(50, ok);
        repeat (4) @(negedge clk);
        req = '0;
        wait_done(50, ok, waited);
        repeat (2) @(negedge clk);
`endif
        run_job(4'b0101, 16'd5, 2);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_delay_arbiter.md
# shared_delay_arbiter

Shares one cycle-delay counter among `NUM_REQ` requesters that each need a programmable wait, for example LCD init delays, debounce windows and SPI settle times. Requests are granted round-robin, one at a time. The granted requester's delay is counted on the shared counter, and completion is signalled with a one-cycle `done` pulse. The block sits between the peripheral FSMs and replaces per-FSM counter instances.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `COUNT_W`, default 16: width of each requested delay and of the internal counter.
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `req` input, `NUM_REQ`: level request per requester; held high until `done` for that requester.
- `req_cycles` input, `NUM_REQ*COUNT_W`: delay per requester; slice i is `[i*COUNT_W +: COUNT_W]`; sampled only at grant.
- `busy` output, 1: high in RUN and DONE states.
- `grant_id` output, `$clog2(NUM_REQ)`: index of current/last granted requester.
- `done` output, `NUM_REQ`: one-hot one-cycle completion pulse, bit `grant_id`.
- `remaining` output, `COUNT_W`: target-1-count during RUN, 0 otherwise.

## Operation
- FSM states are IDLE, RUN and DONE. All outputs are registered or decoded from state only; there are no combinational paths from `req`.
- **IDLE:**
  - If any `req` bit is high at a clock edge, the winner is the first set bit searching upward from `rr_ptr` with wrap-around.
  - At that edge: `grant_id` takes the winner, `target` latches `req_cycles[winner]`, `count` goes to 0, and the state goes to RUN.
- **Zero delay:** `req_cycles` equal to 0 is latched as 1.
- **RUN:**
  - `count` increments by 1 each edge.
  - At the edge where `count == target-1`, the state goes to DONE.
  - The count never wraps, because the target is at most 2^COUNT_W-1.
- **DONE:**
  - `done[grant_id]` = 1 for exactly this cycle.
  - Next edge: state goes to IDLE and `rr_ptr` goes to `(grant_id+1) mod NUM_REQ`.
- **Requester obligation:** deassert `req` at the edge that ends the `done` cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- **Requests during RUN or DONE:** `req` changes on non-granted lines are ignored until IDLE. Pending requests are not lost, because they are levels.
- **Fairness:** with all `req` lines high, grants cycle 0,1,2,...,NUM_REQ-1,0,...
- **Reset (including mid-operation):**
  - State goes to IDLE; `rr_ptr`, `grant_id`, `count` and `target` go to 0.
  - `busy` = 0, `done` = 0, `remaining` = 0.
  - Any in-flight delay is discarded with no `done`.

## Timing
- A grant edge E puts the block in RUN at E. `done` is high in the cycle after edge E+target. `busy` is high from E through the end of the `done` cycle.
- The effective delay from the grant edge to the `done` assertion edge is exactly `max(req_cycles,1)` cycles.
- The minimum gap is one IDLE cycle between `done` and the next grant edge. For back-to-back jobs, the next grant edge is E+target+2.
- Arbitration decision latency from `req` rising to the grant edge is 0 to 1 edges when IDLE. Otherwise the request waits for the current job plus round-robin position.

## Configuration
- `SHARED_DELAY_ABORT_EN`, when defined:
  - In RUN, if `req[grant_id]` is sampled low at an edge, that edge moves the state to IDLE.
  - No `done` is issued.
  - `rr_ptr` advances as on normal completion.
  - An abort at the same edge as `count == target-1` has priority; no `done` is issued.
- When not defined, `req[grant_id]` is ignored during RUN and every grant ends with `done`.

## Test plan
- **Reset values:** assert `reset` for 2 cycles -> `busy` = 0, `done` = 0, `grant_id` = 0, `remaining` = 0.
- **Single request:** `req` = 0001, `req_cycles[0]` = 5 -> `done` = 0001 exactly 5 edges after grant, one cycle wide; `busy` high for 6 cycles.
- **Zero delay:** `req_cycles[2]` = 0, `req` = 0100 -> `done` = 0100 one edge after grant, `grant_id` = 2.
- **Round-robin:** all `req` held high, each requester dropping its `req` after its own `done`, delays 3 -> grant order 0,1,2,3; each `done` spaced by target+2 = 5 cycles.
- **Mid-operation reset:** reset asserted while RUN with `count` = 7 of target 20 -> next cycle IDLE, no `done` ever for that job; the next grant starts from requester 0.
- **Abort with `SHARED_DELAY_ABORT_EN`:** grant 1 with delay 10, drop `req[1]` at `count` = 4 -> IDLE next edge, no `done`; the next grant goes to requester 2 if pending.
